sha3_absorb_ctrl: RTL and testbench

- Sequencer for the SHA3 sponge: accepts AXI-Stream message words and drives the 1600-bit state register's write, XOR and padding controls.
- Starts each 24-round Keccak permutation and steps the round index.
- Repeats absorb/permute per rate-sized block, then presents digest-ready with a valid/ready handshake.
- Sits between the upstream AXI-Stream source and the state register / round datapath.

---
 rtl/sha3_pkg.sv | 36 +++
 rtl/sha3_round_cnt.sv | 55 +++++
 rtl/sha3_absorb_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_sha3_absorb_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared types, constants and rate helper for the SHA3 absorb sequencer.
package sha3_pkg;

    localparam int unsigned KECCAK_ROUNDS = 24;
    localparam int unsigned STATE_BITS    = 1600;
    localparam int unsigned IDX_W         = 8;
    localparam int unsigned ROUND_W       = 5;

    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ABSORB  = 3'd1,
        PAD     = 3'd2,
        PERMUTE = 3'd3,
        SQUEEZE = 3'd4
    } ctrl_state_t;

    // Stream words per rate block: (1600 - 2*d) / data_width.
    function automatic logic [IDX_W-1:0] rate_words(input mode_t mode, input int unsigned data_width);
        int unsigned d;
        case (mode)
            SHA3_224: d = 224;
            SHA3_256: d = 256;
            SHA3_384: d = 384;
            default:  d = 512;
        endcase
        return IDX_W'((STATE_BITS - 2 * d) / data_width);
    endfunction

endpackage

// File: rtl/sha3_round_cnt.sv
// Keccak round sequencer: a start pulse yields ROUNDS consecutive round_en cycles.
module sha3_round_cnt
    import sha3_pkg::*;
#(
    parameter int unsigned ROUNDS = KECCAK_ROUNDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               round_en,
    output logic [ROUND_W-1:0] round_idx,
    output logic               last_round
);

    localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(ROUNDS - 1);

    logic               active_q, active_d;
    logic [ROUND_W-1:0] idx_q, idx_d;
    logic               last_q, last_d;

    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        if (start) begin
            active_d = 1'b1;
            idx_d    = '0;
        end else if (active_q) begin
            if (idx_q == LAST_IDX) begin
                active_d = 1'b0;
                idx_d    = '0;
            end else begin
                idx_d = idx_q + ROUND_W'(1);
            end
        end
        // Registered look-ahead so last_round lines up with the final round cycle.
        last_d = active_d && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
        end
    end

    assign round_en   = active_q;
    assign round_idx  = idx_q;
    assign last_round = last_q;

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// SHA3 sponge sequencer: absorbs AXI-Stream words, pads, runs permutations, hands off digest.
// Optional SHA3_PERF_CNT_EN adds saturating perf_blocks / perf_cycles counters.
module sha3_absorb_ctrl
    import sha3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ROUNDS     = KECCAK_ROUNDS
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic               TVALID,
    output logic               TREADY,
    input  logic               TLAST,
    input  logic [1:0]         TUSER,
    output logic               wr_en,
    output logic [IDX_W-1:0]   wr_idx,
    output logic               clr_state,
    output logic               pad_en,
    output logic [IDX_W-1:0]   pad_start,
    output logic [IDX_W-1:0]   pad_end,
    output logic               perm_start,
    output logic               round_en,
    output logic [ROUND_W-1:0] round_idx,
    output logic [1:0]         mode,
    output logic               digest_valid,
    input  logic               digest_ready
`ifdef SHA3_PERF_CNT_EN
    ,
    output logic [15:0]        perf_blocks,
    output logic [31:0]        perf_cycles
`endif
);

    ctrl_state_t      state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    mode_t            mode_q, mode_d;
    logic             pad_pending_q, pad_pending_d;
    logic             done_q, done_d;

    logic             tready_q, tready_d;
    logic             pad_en_q, pad_en_d;
    logic [IDX_W-1:0] pad_start_q, pad_start_d;
    logic [IDX_W-1:0] pad_end_q, pad_end_d;
    logic             perm_start_q;
    logic             digest_valid_q, digest_valid_d;

    logic             beat;
    logic [IDX_W-1:0] beat_idx;
    logic [IDX_W-1:0] rw;
    logic             last_word;
    mode_t            mode_sel;
    logic             rc_start;
    logic             rc_last;

    // Mode is taken from TUSER only on the first beat of a message.
    assign mode_sel  = (state_q == IDLE) ? mode_t'(TUSER) : mode_q;
    assign rw        = rate_words(mode_sel, DATA_WIDTH);
    assign beat      = TVALID & tready_q;
    assign beat_idx  = (state_q == ABSORB) ? cnt_q : '0;
    assign last_word = (beat_idx == rw - IDX_W'(1));

    sha3_round_cnt #(
        .ROUNDS(ROUNDS)
    ) u_round_cnt (
        .clk        (ACLK),
        .rst_n      (ARESETn),
        .start      (rc_start),
        .round_en   (round_en),
        .round_idx  (round_idx),
        .last_round (rc_last)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            mode_q         <= SHA3_224;
            pad_pending_q  <= 1'b0;
            done_q         <= 1'b0;
            tready_q       <= 1'b0;
            pad_en_q       <= 1'b0;
            pad_start_q    <= '0;
            pad_end_q      <= '0;
            perm_start_q   <= 1'b0;
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mode_q         <= mode_d;
            pad_pending_q  <= pad_pending_d;
            done_q         <= done_d;
            tready_q       <= tready_d;
            pad_en_q       <= pad_en_d;
            pad_start_q    <= pad_start_d;
            pad_end_q      <= pad_end_d;
            perm_start_q   <= rc_start;
            digest_valid_q <= digest_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        pad_pending_d = pad_pending_q;
        done_d        = done_q;
        case (state_q)
            IDLE, ABSORB: begin
                if (beat) begin
                    mode_d = mode_sel;
                    if (TLAST && !last_word) begin
                        state_d = PAD;
                        cnt_d   = beat_idx + IDX_W'(1);
                    end else if (last_word) begin
                        // Message ending exactly on a block boundary needs a pad-only block.
                        state_d       = PERMUTE;
                        cnt_d         = '0;
                        pad_pending_d = TLAST;
                    end else begin
                        state_d = ABSORB;
                        cnt_d   = beat_idx + IDX_W'(1);
                    end
                end
            end
            PAD: begin
                state_d = PERMUTE;
                done_d  = 1'b1;
            end
            PERMUTE: begin
                if (rc_last) begin
                    cnt_d = '0;
                    if (done_q) begin
                        state_d = SQUEEZE;
                    end else if (pad_pending_q) begin
                        state_d       = PAD;
                        pad_pending_d = 1'b0;
                    end else begin
                        state_d = ABSORB;
                    end
                end
            end
            SQUEEZE: begin
                if (digest_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they track state_q exactly.
    always_comb begin
        tready_d       = (state_d == IDLE) || (state_d == ABSORB);
        pad_en_d       = (state_d == PAD);
        pad_start_d    = '0;
        pad_end_d      = '0;
        digest_valid_d = (state_d == SQUEEZE);
        rc_start       = (state_d == PERMUTE) && (state_q != PERMUTE);
        if (pad_en_d) begin
            pad_start_d = cnt_d;
            pad_end_d   = rw - IDX_W'(1);
        end
    end

    assign TREADY       = tready_q;
    assign wr_en        = beat;
    assign wr_idx       = beat ? beat_idx : '0;
    assign clr_state    = digest_valid_q & digest_ready;
    assign pad_en       = pad_en_q;
    assign pad_start    = pad_start_q;
    assign pad_end      = pad_end_q;
    assign perm_start   = perm_start_q;
    assign mode         = mode_q;
    assign digest_valid = digest_valid_q;

`ifdef SHA3_PERF_CNT_EN
    logic [15:0] perf_blocks_q, perf_blocks_d;
    logic [31:0] perf_cycles_q, perf_cycles_d;

    // Saturating activity counters, cleared only by reset.
    always_comb begin
        perf_blocks_d = perf_blocks_q;
        perf_cycles_d = perf_cycles_q;
        if (perm_start_q && (perf_blocks_q != 16'hFFFF)) begin
            perf_blocks_d = perf_blocks_q + 16'd1;
        end
        if ((state_q != IDLE) && (perf_cycles_q != 32'hFFFF_FFFF)) begin
            perf_cycles_d = perf_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            perf_blocks_q <= '0;
            perf_cycles_q <= '0;
        end else begin
            perf_blocks_q <= perf_blocks_d;
            perf_cycles_q <= perf_cycles_d;
        end
    end

    assign perf_blocks = perf_blocks_q;
    assign perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Directed self-checking bench for sha3_absorb_ctrl at DATA_WIDTH=64.
module tb_sha3_absorb_ctrl;

    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic       TVALID;
    logic       TREADY;
    logic       TLAST;
    logic [1:0] TUSER;
    logic       wr_en;
    logic [7:0] wr_idx;
    logic       clr_state;
    logic       pad_en;
    logic [7:0] pad_start;
    logic [7:0] pad_end;
    logic       perm_start;
    logic       round_en;
    logic [4:0] round_idx;
    logic [1:0] mode;
    logic       digest_valid;
    logic       digest_ready;
`ifdef SHA3_PERF_CNT_EN
    logic [15:0] perf_blocks;
    logic [31:0] perf_cycles;
`endif

    always #5 ACLK = ~ACLK;

    sha3_absorb_ctrl #(
        .DATA_WIDTH(64),
        .ROUNDS    (24)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .TVALID      (TVALID),
        .TREADY      (TREADY),
        .TLAST       (TLAST),
        .TUSER       (TUSER),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .clr_state   (clr_state),
        .pad_en      (pad_en),
        .pad_start   (pad_start),
        .pad_end     (pad_end),
        .perm_start  (perm_start),
        .round_en    (round_en),
        .round_idx   (round_idx),
        .mode        (mode),
        .digest_valid(digest_valid),
        .digest_ready(digest_ready)
`ifdef SHA3_PERF_CNT_EN
        ,
        .perf_blocks (perf_blocks),
        .perf_cycles (perf_cycles)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Event log gathered at every falling edge.
    int   cyc        = 0;
    int   n_perm     = 0;
    int   n_round    = 0;
    int   seq_bad    = 0;
    int   tready_bad = 0;
    int   wr_bad     = 0;
    int   wr_q[$];
    int   wr_cyc_q[$];
    int   lastbeat_cyc_q[$];
    int   pad_q[$];
    int   perm_cyc_q[$];
    int   r23_cyc_q[$];
    int   dv_rise_q[$];
    logic prev_re  = 1'b0;
    logic [4:0] prev_idx = 5'd0;
    logic prev_dv  = 1'b0;

    always @(negedge ACLK) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            wr_q.push_back(int'(wr_idx));
            wr_cyc_q.push_back(cyc);
            if (TLAST) lastbeat_cyc_q.push_back(cyc);
            if (!TVALID) wr_bad <= wr_bad + 1;
        end
        if (pad_en) pad_q.push_back(int'(pad_start) * 256 + int'(pad_end));
        if (perm_start) begin
            n_perm <= n_perm + 1;
            perm_cyc_q.push_back(cyc);
        end
        if (round_en) begin
            n_round <= n_round + 1;
            if (round_idx == 5'd23) r23_cyc_q.push_back(cyc);
        end
        if ((round_en && (round_idx != (prev_re ? prev_idx + 5'd1 : 5'd0))) ||
            (perm_start != (round_en && (round_idx == 5'd0))))
            seq_bad <= seq_bad + 1;
        if (TREADY && (round_en || pad_en || digest_valid)) tready_bad <= tready_bad + 1;
        if (digest_valid && !prev_dv) dv_rise_q.push_back(cyc);
        prev_re  <= round_en;
        prev_idx <= round_idx;
        prev_dv  <= digest_valid;
    end

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic any_out();
        return |{TREADY, wr_en, wr_idx, clr_state, pad_en, pad_start, pad_end,
                 perm_start, round_en, round_idx, mode, digest_valid};
    endfunction

    int b_wr, b_pad, b_perm, b_round, b_lb, b_pc, b_r23, b_dv;

    task automatic snap();
        b_wr    = wr_q.size();
        b_pad   = pad_q.size();
        b_perm  = n_perm;
        b_round = n_round;
        b_lb    = lastbeat_cyc_q.size();
        b_pc    = perm_cyc_q.size();
        b_r23   = r23_cyc_q.size();
        b_dv    = dv_rise_q.size();
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_beat(input logic [1:0] user, input logic last);
        int n;
        n = 0;
        TVALID = 1'b1;
        TUSER  = user;
        TLAST  = last;
        @(negedge ACLK);
        while (!TREADY && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        if (!TREADY) chk("beat_accept_timeout", 32'(TREADY), 1);
        tick();
        TVALID = 1'b0;
        TLAST  = 1'b0;
    endtask

    task automatic send_msg(input logic [1:0] user, input int nbeats);
        for (int i = 0; i < nbeats; i++) send_beat(user, i == nbeats - 1);
    endtask

    task automatic finish_digest(input logic [1:0] exp_mode, input int hold);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        while (!digest_valid && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        chk("digest_valid", 32'(digest_valid), 1);
        chk("mode", 32'(mode), 32'(exp_mode));
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            if (!digest_valid || TREADY || clr_state) bad++;
        end
        if (hold > 0) chk("digest_hold", bad, 0);
        @(negedge ACLK);
        digest_ready = 1'b1;
        #1;
        chk("clr_state", 32'(clr_state), 1);
        tick();
        digest_ready = 1'b0;
        @(negedge ACLK);
        chk("post_idle", 32'({digest_valid, clr_state, TREADY}), 1);
        tick();
    endtask

    task automatic chk_wr(input string tag, input int first, input int count);
        chk({tag, "_wr_count"}, wr_q.size() - b_wr, count);
        for (int i = 0; i < count; i++) chk({tag, "_wr_idx"}, qat(wr_q, b_wr + i), first + i);
    endtask

    initial begin
        int n;
        int bad;
        ARESETn      = 1'b1;
        TVALID       = 1'b0;
        TLAST        = 1'b0;
        TUSER        = 2'd0;
        digest_ready = 1'b0;
        #2 ARESETn   = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_outputs", 32'(any_out()), 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();
        chk("idle_tready", 32'(TREADY), 1);

        // SHA3-256, 3 beats
        snap();
        send_msg(2'd1, 3);
        finish_digest(2'd1, 0);
        chk_wr("t256", 0, 3);
        chk("t256_pad_count", pad_q.size() - b_pad, 1);
        chk("t256_pad", qat(pad_q, b_pad), 3 * 256 + 16);
        chk("t256_perm_count", n_perm - b_perm, 1);
        chk("t256_round_count", n_round - b_round, 24);
        chk("t256_beat_to_round", qat(perm_cyc_q, b_pc) - qat(lastbeat_cyc_q, b_lb), 2);
        chk("t256_round23_to_dv", qat(dv_rise_q, b_dv) - qat(r23_cyc_q, b_r23), 1);

        // SHA3-512, 9 beats: full block then pad-only block
        snap();
        send_msg(2'd3, 9);
        finish_digest(2'd3, 0);
        chk_wr("t512", 0, 9);
        chk("t512_pad_count", pad_q.size() - b_pad, 1);
        chk("t512_pad", qat(pad_q, b_pad), 0 * 256 + 8);
        chk("t512_perm_count", n_perm - b_perm, 2);
        chk("t512_round_count", n_round - b_round, 48);

        // SHA3-224, 20 beats: block boundary after word 17
        snap();
        send_msg(2'd0, 20);
        finish_digest(2'd0, 0);
        chk("t224_wr_count", wr_q.size() - b_wr, 20);
        chk("t224_wr17", qat(wr_q, b_wr + 17), 17);
        chk("t224_wr18", qat(wr_q, b_wr + 18), 0);
        chk("t224_wr19", qat(wr_q, b_wr + 19), 1);
        chk("t224_perm_after_wr17", qat(perm_cyc_q, b_pc) - qat(wr_cyc_q, b_wr + 17), 1);
        chk("t224_pad", qat(pad_q, b_pad), 2 * 256 + 17);
        chk("t224_perm_count", n_perm - b_perm, 2);

        // Backpressure on both stream and digest sides
        snap();
        bad = 0;
        send_beat(2'd1, 1'b0);
        repeat (2) begin
            @(negedge ACLK);
            if (wr_en || !TREADY) bad++;
        end
        tick();
        chk("bp_gap_no_wr", bad, 0);
        send_beat(2'd1, 1'b0);
        send_beat(2'd1, 1'b1);
        finish_digest(2'd1, 10);
        chk_wr("bp", 0, 3);
        chk("bp_pad", qat(pad_q, b_pad), 3 * 256 + 16);

        // Asynchronous reset in the middle of a permutation
        send_msg(2'd1, 2);
        n = 0;
        while (!(round_en && round_idx == 5'd10) && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("reach_round10", 32'(round_idx), 10);
        #2 ARESETn = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(any_out()), 0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        tick();
        snap();
        send_msg(2'd2, 1);
        finish_digest(2'd2, 0);
        chk_wr("t384", 0, 1);
        chk("t384_pad", qat(pad_q, b_pad), 1 * 256 + 12);

        // TUSER change after the first beat is ignored
        snap();
        send_beat(2'd1, 1'b0);
        send_beat(2'd3, 1'b1);
        finish_digest(2'd1, 0);
        chk("tuser_pad", qat(pad_q, b_pad), 2 * 256 + 16);

        chk("round_sequence_errors", seq_bad, 0);
        chk("tready_while_busy", tready_bad, 0);
        chk("wr_without_valid", wr_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
